// File: rtl/rv_lzc_iter_if.sv
// Request/response bundle for the iterative zero counter.
// The requester drives req_* and rsp_ready; the counter drives req_ready and rsp_*.
interface rv_lzc_iter_if #(
  parameter int unsigned N    = 64,
  parameter int unsigned TAGW = 4
);
  localparam int unsigned CW = $clog2(N) + 1;

  logic            req_valid;
  logic            req_ready;
  logic [N-1:0]    req_data;
  logic            req_mode;
  logic [TAGW-1:0] req_tag;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [CW-1:0]   rsp_cnt;
  logic            rsp_zero;
  logic [TAGW-1:0] rsp_tag;

  modport master (
    output req_valid, req_data, req_mode, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_cnt, rsp_zero, rsp_tag
  );

  modport slave (
    input  req_valid, req_data, req_mode, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_cnt, rsp_zero, rsp_tag
  );
endinterface

// File: rtl/rv_lzc_iter.sv
// Iterative leading/trailing zero counter: scans CHUNK bits per cycle from the counted
// end of a latched operand and answers with the count and the caller's tag.
module rv_lzc_iter #(
  parameter int unsigned N     = 64,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned TAGW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  rv_lzc_iter_if.slave     bus
);
  localparam int unsigned LOGN      = $clog2(N);
  localparam int unsigned CW        = LOGN + 1;
  localparam int unsigned NCH       = N / CHUNK;
  localparam int unsigned KW        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned LOG_CHUNK = $clog2(CHUNK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [N-1:0]    data_q, data_d;
  logic            mode_q, mode_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            zero_q, zero_d;

  logic [CW-1:0]    offset;
  logic [CW-1:0]    shamt;
  logic [CHUNK-1:0] chunk;
  logic [CW-1:0]    local_cnt;

  // Zeros counted from the chunk MSB (lead=1) or LSB (lead=0); only meaningful for c != 0.
  function automatic logic [CW-1:0] zeros_from_end(input logic [CHUNK-1:0] c, input logic lead);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      if (!found) begin
        if (c[lead ? (int'(CHUNK) - 1 - i) : i]) found = 1'b1;
        else                                     n     = n + CW'(1);
      end
    end
    return n;
  endfunction

  // Chunk k sits k*CHUNK bits in from the counted end of the operand.
  assign offset    = CW'(k_q) << LOG_CHUNK;
  assign shamt     = mode_q ? (CW'(N - CHUNK) - offset) : offset;
  assign chunk     = CHUNK'(data_q >> shamt);
  assign local_cnt = zeros_from_end(chunk, mode_q);

  assign bus.req_ready = (state_q == S_IDLE) && !reset;
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_cnt   = cnt_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_tag   = tag_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    k_d     = k_q;
    data_d  = data_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          data_d  = bus.req_data;
          mode_d  = bus.req_mode;
          tag_d   = bus.req_tag;
          k_d     = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (chunk != '0) begin
          cnt_d   = offset + local_cnt;
          zero_d  = 1'b0;
          state_d = S_DONE;
        end else if (k_q == KW'(NCH - 1)) begin
          cnt_d   = CW'(N);
          zero_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
      tag_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      k_q     <= k_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_rv_lzc_iter.sv
// Self-checking bench for rv_lzc_iter: directed vector table, stall/abort sequences and
// a random mixed-mode regression against a bit-serial reference count.
module tb_rv_lzc_iter;
  localparam int unsigned N     = 64;
  localparam int unsigned CHUNK = 8;
  localparam int unsigned TAGW  = 4;
  localparam int unsigned NCH   = N / CHUNK;

  typedef struct {
    logic [N-1:0]    data;
    logic            mode;
    logic [TAGW-1:0] tag;
    int              cnt;
    logic            zero;
    int              lat;
  } vec_t;

  typedef struct {
    int              cnt;
    logic            zero;
    logic [TAGW-1:0] tag;
    int              lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rv_lzc_iter_if #(.N(N), .TAGW(TAGW)) bus ();

  rv_lzc_iter #(.N(N), .CHUNK(CHUNK), .TAGW(TAGW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Bit-serial reference: walk from the counted end until the first set bit.
  function automatic int ref_cnt(input logic [N-1:0] d, input logic lead);
    for (int i = 0; i < int'(N); i++)
      if (d[lead ? int'(N) - 1 - i : i]) return i;
    return int'(N);
  endfunction

  task automatic push_exp(input int cnt, input logic zero, input logic [TAGW-1:0] tag, input int lat);
    exp_t e;
    e.cnt = cnt; e.zero = zero; e.tag = tag; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Present a request at a negedge, wait for acceptance, then scramble req_data.
  task automatic send(input logic [N-1:0] d, input logic m, input logic [TAGW-1:0] t);
    int waited;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_data  = d;
    bus.req_mode  = m;
    bus.req_tag   = t;
    waited = 0;
    while (!bus.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("accept_timeout", 64'(waited), 64'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_data  = {$urandom, $urandom};
    bus.req_mode  = ~m;
  endtask

  // Called just after the accept edge: measure latency, compare against the scoreboard, handshake.
  task automatic collect(input string name);
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.rsp_valid && lat < 100);
    if (exp_q.size() == 0) begin
      check({name, "_scoreboard_empty"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check({name, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    check({name, "_cnt"},   64'(bus.rsp_cnt),   64'(e.cnt));
    check({name, "_zero"},  64'(bus.rsp_zero),  64'(e.zero));
    check({name, "_tag"},   64'(bus.rsp_tag),   64'(e.tag));
    check({name, "_lat"},   64'(lat),           64'(e.lat));
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check({name, "_idle_after_hs"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    vec_t vecs[12];
    logic [N-1:0] d;
    logic         m;
    int           c;
    int           seen;
    logic [6:0]   held_cnt;
    logic [TAGW-1:0] held_tag;

    vecs[0]  = '{64'h0000_0000_0010_0000, 1'b1, 4'd3,  43, 1'b0, 6};
    vecs[1]  = '{64'h0000_0000_0010_0000, 1'b0, 4'd5,  20, 1'b0, 3};
    vecs[2]  = '{64'h0,                   1'b1, 4'd1,  64, 1'b1, 8};
    vecs[3]  = '{64'h0,                   1'b0, 4'd2,  64, 1'b1, 8};
    vecs[4]  = '{64'h8000_0000_0000_0000, 1'b1, 4'd7,  0,  1'b0, 1};
    vecs[5]  = '{64'h0000_0000_0000_0001, 1'b0, 4'd8,  0,  1'b0, 1};
    vecs[6]  = '{64'h8000_0000_0000_0000, 1'b0, 4'd9,  63, 1'b0, 8};
    vecs[7]  = '{64'h0000_0000_0000_0001, 1'b1, 4'd10, 63, 1'b0, 8};
    vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd15, 0,  1'b0, 1};
    vecs[9]  = '{64'h0000_0001_0000_0000, 1'b0, 4'd4,  32, 1'b0, 5};
    vecs[10] = '{64'h00F0_0000_0000_0000, 1'b1, 4'd6,  8,  1'b0, 2};
    vecs[11] = '{64'h0000_0000_0000_0100, 1'b0, 4'd11, 8,  1'b0, 2};

    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.req_mode  = 1'b0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_cnt",   64'(bus.rsp_cnt),   64'd0);
    check("rst_rsp_zero",  64'(bus.rsp_zero),  64'd0);
    check("rst_rsp_tag",   64'(bus.rsp_tag),   64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

    // Directed vector table
    foreach (vecs[i]) begin
      push_exp(vecs[i].cnt, vecs[i].zero, vecs[i].tag, vecs[i].lat);
      send(vecs[i].data, vecs[i].mode, vecs[i].tag);
      collect($sformatf("vec%0d", i));
    end

    // Back-pressure: response held for 5 cycles while the next request waits
    push_exp(0, 1'b0, 4'd12, 1);
    send(64'h0000_0000_0000_0001, 1'b0, 4'd12);
    bus.req_valid = 1'b1;
    bus.req_data  = 64'h0000_0000_0010_0000;
    bus.req_mode  = 1'b1;
    bus.req_tag   = 4'd13;
    @(posedge clk);
    @(negedge clk);
    check("stall_valid", 64'(bus.rsp_valid), 64'd1);
    held_cnt = bus.rsp_cnt;
    held_tag = bus.rsp_tag;
    check("stall_cnt", 64'(held_cnt), 64'd0);
    check("stall_tag", 64'(held_tag), 64'd12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_req_ready", i), 64'(bus.req_ready), 64'd0);
      check($sformatf("stall%0d_valid", i),     64'(bus.rsp_valid), 64'd1);
      check($sformatf("stall%0d_cnt", i),       64'(bus.rsp_cnt),   64'(held_cnt));
      check($sformatf("stall%0d_tag", i),       64'(bus.rsp_tag),   64'(held_tag));
    end
    void'(exp_q.pop_front());
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("stall_release_valid", 64'(bus.rsp_valid), 64'd0);
    check("stall_release_ready", 64'(bus.req_ready), 64'd1);
    push_exp(43, 1'b0, 4'd13, 6);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_data  = '1;
    collect("pending_req");

    // Reset during the third scan cycle of an all-zero operand aborts it
    push_exp(64, 1'b1, 4'd14, 8);
    send(64'h0, 1'b1, 4'd14);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_valid",     64'(bus.rsp_valid), 64'd0);
    check("abort_req_ready", 64'(bus.req_ready), 64'd0);
    check("abort_cnt",       64'(bus.rsp_cnt),   64'd0);
    check("abort_tag",       64'(bus.rsp_tag),   64'd0);
    @(negedge clk);
    reset = 1'b0;
    void'(exp_q.pop_back());
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("abort_no_rsp", 64'(seen), 64'd0);
    push_exp(20, 1'b0, 4'd1, 3);
    send(64'h0000_0000_0010_0000, 1'b0, 4'd1);
    collect("after_abort");

    // Random mixed-mode regression
    for (int i = 0; i < 40; i++) begin
      d = {$urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: d = d >> $urandom_range(0, 63);
        1: d = d << $urandom_range(0, 63);
        2: d = (i % 5 == 0) ? '0 : (64'd1 << $urandom_range(0, 63));
        default: ;
      endcase
      c = ref_cnt(d, m);
      push_exp(c, c == int'(N), 4'(i), (c == int'(N)) ? int'(NCH) : c / int'(CHUNK) + 1);
      send(d, m, 4'(i));
      collect($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
